// File: rtl/prng_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prng_pkg
// Purpose  : Shared word width, checker state encoding and default seed.
// Revision : 1.0  initial release
// ============================================================================
package prng_pkg;

    localparam int          WORD_W       = 32;
    localparam int          MISS_W       = 4;
    localparam logic [31:0] DEFAULT_SEED = 32'd20240301;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

endpackage : prng_pkg
`default_nettype wire

// File: rtl/prng_stream_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : prng_stream_checker_if
// Purpose  : Valid/ready word stream between a PRNG source and its checker.
// Revision : 1.0  initial release
// ============================================================================
interface prng_stream_checker_if;
    import prng_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface : prng_stream_checker_if
`default_nettype wire

// File: rtl/prng_stream_checker_generator.sv
`default_nettype none
// ============================================================================
// Module   : Generator
// Purpose  : Combinational xorshift32 step (shifts 13, 17, 5).
// Revision : 1.0  initial release
// ============================================================================
module Generator
    import prng_pkg::*;
(
    input  logic [WORD_W-1:0] x_i,
    output logic [WORD_W-1:0] y_o
);

    logic [WORD_W-1:0] s1_w;
    logic [WORD_W-1:0] s2_w;

    assign s1_w = x_i  ^ (x_i  << 13);
    assign s2_w = s1_w ^ (s1_w >> 17);
    assign y_o  = s2_w ^ (s2_w << 5);

endmodule : Generator
`default_nettype wire

// File: rtl/prng_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : prng_stream_checker
// Purpose  : Checks that a word stream follows the Generator recurrence,
//            with lock tracking, mismatch pulses and saturating counters.
// Revision : 1.0  initial release
// ============================================================================
module prng_stream_checker
    import prng_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int RESYNC_MISSES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   use_seed,
    input  logic [WORD_W-1:0]      seed,
    input  logic                   abort,
    prng_stream_checker_if.slave   s,
    output logic                   locked,
    output logic                   match_pulse,
    output logic                   err_pulse,
    output logic [CNT_W-1:0]       match_cnt,
    output logic [CNT_W-1:0]       err_cnt
);

    localparam logic [MISS_W-1:0] RESYNC_LIMIT = MISS_W'(RESYNC_MISSES);
    localparam logic [CNT_W-1:0]  CNT_MAX      = {CNT_W{1'b1}};

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   prev_q, prev_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic [CNT_W-1:0]    mcnt_q, mcnt_d;
    logic [CNT_W-1:0]    ecnt_q, ecnt_d;
    logic                mpulse_q, mpulse_d;
    logic                epulse_q, epulse_d;

    logic [WORD_W-1:0]   expected;
    logic                ready;
    logic                accept;
    logic                hit;
    logic [MISS_W-1:0]   miss_inc;

    Generator u_gen (
        .x_i (prev_q),
        .y_o (expected)
    );

    assign ready    = (state_q != ST_IDLE) && !start && !abort;
    assign accept   = s.s_valid && ready;
    assign hit      = (s.s_data == expected);
    assign miss_inc = miss_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        miss_d   = miss_q;
        mcnt_d   = mcnt_q;
        ecnt_d   = ecnt_q;
        mpulse_d = 1'b0;
        epulse_d = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
        end else if (start) begin
            mcnt_d = '0;
            ecnt_d = '0;
            miss_d = '0;
            if (use_seed) begin
                prev_d  = seed;
                state_d = ST_CHECK;
            end else begin
                state_d = ST_SYNC;
            end
        end else if (accept) begin
            unique case (state_q)
                ST_SYNC: begin
                    prev_d  = s.s_data;
                    state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    if (hit) begin
                        prev_d   = s.s_data;
                        miss_d   = '0;
                        mpulse_d = 1'b1;
                        if (mcnt_q != CNT_MAX) mcnt_d = mcnt_q + 1'b1;
                    end else begin
                        // Follow the reference so one bad word costs one error.
                        prev_d   = expected;
                        epulse_d = 1'b1;
                        if (ecnt_q != CNT_MAX) ecnt_d = ecnt_q + 1'b1;
                        if (miss_inc == RESYNC_LIMIT) begin
                            miss_d  = '0;
                            state_d = ST_SYNC;
                        end else begin
                            miss_d  = miss_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            prev_q   <= '0;
            miss_q   <= '0;
            mcnt_q   <= '0;
            ecnt_q   <= '0;
            mpulse_q <= 1'b0;
            epulse_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            miss_q   <= miss_d;
            mcnt_q   <= mcnt_d;
            ecnt_q   <= ecnt_d;
            mpulse_q <= mpulse_d;
            epulse_q <= epulse_d;
        end
    end

    assign s.s_ready   = ready;
    assign locked      = (state_q == ST_CHECK);
    assign match_pulse = mpulse_q;
    assign err_pulse   = epulse_q;
    assign match_cnt   = mcnt_q;
    assign err_cnt     = ecnt_q;

endmodule : prng_stream_checker
`default_nettype wire

// File: tb/tb_prng_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_prng_stream_checker
// Purpose  : Self-checking bench: directed vector table plus randomized stream
//            against a rule-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_prng_stream_checker;
    import prng_pkg::*;

    localparam logic [31:0] SEED = 32'd20240301;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, use_seed, abort, valid;
    logic [31:0] seed, data;

    logic        locked, mp, ep, locked4, mp4, ep4;
    logic [15:0] mc, ec;
    logic [3:0]  mc4, ec4;

    prng_stream_checker_if sif ();
    prng_stream_checker_if sif4 ();
    assign sif.s_valid  = valid;
    assign sif.s_data   = data;
    assign sif4.s_valid = valid;
    assign sif4.s_data  = data;

    prng_stream_checker #(.CNT_W(16), .RESYNC_MISSES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .use_seed(use_seed),
        .seed(seed), .abort(abort), .s(sif.slave), .locked(locked),
        .match_pulse(mp), .err_pulse(ep), .match_cnt(mc), .err_cnt(ec)
    );

    prng_stream_checker #(.CNT_W(4), .RESYNC_MISSES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .use_seed(use_seed),
        .seed(seed), .abort(abort), .s(sif4.slave), .locked(locked4),
        .match_pulse(mp4), .err_pulse(ep4), .match_cnt(mc4), .err_cnt(ec4)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] gen(input logic [31:0] x);
        logic [31:0] v;
        v = x;
        v = v ^ (v << 13);
        v = v ^ (v >> 17);
        v = v ^ (v << 5);
        return v;
    endfunction

    function automatic logic [31:0] gpow(input logic [31:0] x, input int n);
        logic [31:0] v;
        v = x;
        for (int k = 0; k < n; k++) v = gen(v);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 = idle, 1 = waiting for a sync word, 2 = checking.
    int          m_state = 0;
    logic [31:0] m_prev  = '0;
    int          m_miss  = 0;
    int          m_mc = 0, m_ec = 0, m_mc4 = 0, m_ec4 = 0;
    bit          m_mp = 0, m_ep = 0;
    bit          rdy_seen;

    function automatic bit m_ready();
        return (m_state != 0) && !start && !abort;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    task automatic model_step();
        bit acc;
        acc  = valid && m_ready();
        m_mp = 0;
        m_ep = 0;
        if (!rst_n) begin
            m_state = 0; m_prev = '0; m_miss = 0;
            m_mc = 0; m_ec = 0; m_mc4 = 0; m_ec4 = 0;
        end else if (abort) begin
            m_state = 0;
        end else if (start) begin
            m_mc = 0; m_ec = 0; m_mc4 = 0; m_ec4 = 0; m_miss = 0;
            if (use_seed) begin
                m_prev  = seed;
                m_state = 2;
            end else begin
                m_state = 1;
            end
        end else if (acc && m_state == 1) begin
            m_prev  = data;
            m_state = 2;
        end else if (acc && m_state == 2) begin
            if (data == gen(m_prev)) begin
                m_prev = data;
                m_miss = 0;
                m_mp   = 1;
                m_mc   = sat(m_mc, 65535);
                m_mc4  = sat(m_mc4, 15);
            end else begin
                m_prev = gen(m_prev);
                m_ep   = 1;
                m_ec   = sat(m_ec, 65535);
                m_ec4  = sat(m_ec4, 15);
                m_miss = m_miss + 1;
                if (m_miss == 4) begin
                    m_miss  = 0;
                    m_state = 1;
                end
            end
        end
    endtask

    // Inputs are set by the caller just after an edge; ready is sampled
    // mid-cycle and registered outputs 1 ns after the next edge.
    task automatic tick();
        #2;
        rdy_seen = sif.s_ready;
        chk("s_ready", 32'(sif.s_ready), 32'(m_ready()));
        chk("s_ready4", 32'(sif4.s_ready), 32'(m_ready()));
        @(posedge clk);
        model_step();
        #1;
        chk("locked", 32'(locked), 32'(m_state == 2));
        chk("locked4", 32'(locked4), 32'(m_state == 2));
        chk("match_pulse", 32'(mp), 32'(m_mp));
        chk("err_pulse", 32'(ep), 32'(m_ep));
        chk("match_pulse4", 32'(mp4), 32'(m_mp));
        chk("err_pulse4", 32'(ep4), 32'(m_ep));
        chk("match_cnt", 32'(mc), 32'(m_mc));
        chk("err_cnt", 32'(ec), 32'(m_ec));
        chk("match_cnt4", 32'(mc4), 32'(m_mc4));
        chk("err_cnt4", 32'(ec4), 32'(m_ec4));
    endtask

    task automatic idle_inputs();
        start = 0; use_seed = 0; seed = '0; abort = 0; valid = 0; data = '0;
    endtask

    typedef struct {
        bit          st;
        bit          us;
        logic [31:0] sd;
        bit          ab;
        bit          v;
        logic [31:0] d;
        bit          rdy;
        bit          lk;
        bit          mp;
        bit          ep;
        int          mc;
        int          ec;
    } vec_t;

    function automatic vec_t mk(input bit st, input bit us, input logic [31:0] sd,
                                input bit ab, input bit v, input logic [31:0] d,
                                input bit rdy, input bit lk, input bit mpv,
                                input bit epv, input int mcv, input int ecv);
        vec_t r;
        r.st = st; r.us = us; r.sd = sd; r.ab = ab; r.v = v; r.d = d;
        r.rdy = rdy; r.lk = lk; r.mp = mpv; r.ep = epv; r.mc = mcv; r.ec = ecv;
        return r;
    endfunction

    vec_t tbl [29];

    initial begin
        logic [31:0] src, nxt;
        bit          corrupt;

        // Seeded run, single corruption, lock loss, auto-sync, priority cases.
        tbl[0] = mk(1, 1, SEED, 0, 0, '0, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++)
            tbl[i] = mk(0, 0, '0, 0, 1, gpow(SEED, i), 1, 1, 1, 0, i, 0);
        tbl[11] = mk(0, 0, '0, 0, 0, '0, 1, 1, 0, 0, 10, 0);
        tbl[12] = mk(0, 0, '0, 0, 1, gpow(SEED, 11) ^ 32'h1, 1, 1, 0, 1, 10, 1);
        tbl[13] = mk(0, 0, '0, 0, 1, gpow(SEED, 12), 1, 1, 1, 0, 11, 1);
        tbl[14] = mk(0, 0, '0, 0, 1, gpow(SEED, 13), 1, 1, 1, 0, 12, 1);
        for (int k = 0; k < 4; k++)
            tbl[15+k] = mk(0, 0, '0, 0, 1, gpow(SEED, 14 + k) ^ 32'hFFFF_0000,
                           1, (k < 3), 0, 1, 12, 2 + k);
        tbl[19] = mk(0, 0, '0, 0, 1, 32'h1234_5678, 1, 1, 0, 0, 12, 5);
        tbl[20] = mk(0, 0, '0, 0, 1, gen(32'h1234_5678), 1, 1, 1, 0, 13, 5);
        tbl[21] = mk(1, 0, '0, 0, 0, '0, 0, 0, 0, 0, 0, 0);
        tbl[22] = mk(0, 0, '0, 0, 1, 32'h1, 1, 1, 0, 0, 0, 0);
        tbl[23] = mk(0, 0, '0, 0, 1, gpow(32'h1, 1), 1, 1, 1, 0, 1, 0);
        tbl[24] = mk(0, 0, '0, 0, 1, gpow(32'h1, 2), 1, 1, 1, 0, 2, 0);
        tbl[25] = mk(1, 1, gpow(32'h1, 2), 0, 1, gpow(32'h1, 3), 0, 1, 0, 0, 0, 0);
        tbl[26] = mk(0, 0, '0, 0, 1, gpow(32'h1, 3), 1, 1, 1, 0, 1, 0);
        tbl[27] = mk(1, 0, '0, 1, 0, '0, 0, 0, 0, 0, 1, 0);
        tbl[28] = mk(0, 0, '0, 0, 1, gpow(32'h1, 4), 0, 0, 0, 0, 1, 0);

        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 32'(sif.s_ready), 32'h0);
        chk("reset_locked", 32'(locked), 32'h0);
        chk("reset_pulses", {30'h0, mp, ep}, 32'h0);
        chk("reset_match_cnt", 32'(mc), 32'h0);
        chk("reset_err_cnt", 32'(ec), 32'h0);
        rst_n = 1;

        foreach (tbl[i]) begin
            start = tbl[i].st; use_seed = tbl[i].us; seed = tbl[i].sd;
            abort = tbl[i].ab; valid = tbl[i].v;   data = tbl[i].d;
            tick();
            chk($sformatf("vec%0d_ready", i), 32'(rdy_seen), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d_locked", i), 32'(locked), 32'(tbl[i].lk));
            chk($sformatf("vec%0d_match_pulse", i), 32'(mp), 32'(tbl[i].mp));
            chk($sformatf("vec%0d_err_pulse", i), 32'(ep), 32'(tbl[i].ep));
            chk($sformatf("vec%0d_match_cnt", i), 32'(mc), 32'(tbl[i].mc));
            chk($sformatf("vec%0d_err_cnt", i), 32'(ec), 32'(tbl[i].ec));
        end

        // Saturation of the narrow instance.
        idle_inputs();
        start = 1; use_seed = 1; seed = SEED;
        tick();
        idle_inputs();
        for (int i = 1; i <= 20; i++) begin
            valid = 1; data = gpow(SEED, i);
            tick();
        end
        chk("sat_match_cnt16", 32'(mc), 32'd20);
        chk("sat_match_cnt4", 32'(mc4), 32'd15);
        chk("sat_pulse4", 32'(mp4), 32'h1);

        // Reset in the middle of an accepted beat.
        valid = 1; data = gpow(SEED, 21); rst_n = 0;
        tick();
        chk("midrst_pulses", {30'h0, mp, ep}, 32'h0);
        chk("midrst_locked", 32'(locked), 32'h0);
        chk("midrst_match_cnt", 32'(mc), 32'h0);
        rst_n = 1;
        idle_inputs();

        // Randomized stream with gaps, corruptions, restarts and aborts.
        src = SEED;
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            rst_n = (i != 250);
            if (m_state == 0 ? ($urandom_range(3) == 0) : ($urandom_range(47) == 0)) begin
                start    = 1;
                use_seed = $urandom_range(1);
                seed     = src;
            end
            if ($urandom_range(99) == 0) abort = 1;
            valid   = ($urandom_range(3) != 0);
            nxt     = gen(src);
            corrupt = ($urandom_range(4) == 0);
            data    = corrupt ? (nxt ^ ($urandom() | 32'h1)) : nxt;
            if (valid && rst_n && m_ready()) src = nxt;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_prng_stream_checker
`default_nettype wire

// File: doc/prng_stream_checker.md
# prng_stream_checker

- Receives a stream of 32-bit words over a valid/ready handshake and checks that each word is the next value of the `Generator` recurrence, i.e. `word[n+1] == Generator(word[n])`.
- It is the consuming end of the PRNG stream: it sits behind any block that iterates `Generator` as its seed and emits the results.
- It reports lock, per-beat mismatch pulses and saturating match/error counts.
- It re-synchronises automatically after a run of consecutive mismatches.

## Interface
Parameters:
- `CNT_W`, 16: width of the match and error counters.
- `RESYNC_MISSES`, 4: consecutive mismatches that drop lock. Legal range 1..15.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: one-cycle pulse that arms the checker and clears the counters.
- `use_seed` input 1: sampled with `start`. 1 means `seed` is the reference; 0 means auto-sync on the first word.
- `seed` input 32: reference word, sampled with `start` when `use_seed=1`.
- `abort` input 1: returns the checker to IDLE.
- `s_valid` input 1: stream word valid.
- `s_data` input 32: stream word.
- `s_ready` output 1: checker accepts a word.
- `locked` output 1: high while in CHECK.
- `match_pulse` output 1: one-cycle pulse, registered, for a matching beat.
- `err_pulse` output 1: one-cycle pulse, registered, for a mismatching beat.
- `match_cnt` output CNT_W: saturating count of matching beats.
- `err_cnt` output CNT_W: saturating count of mismatching beats.

## Operation
- **States:** IDLE, SYNC, CHECK.
- **Accept condition:** a beat is accepted when `s_valid && s_ready`.
- **s_ready:** `s_ready = (state != IDLE) && !start && !abort`, combinational from registered state.
- **Internal registers:** `prev` (32 bits) and `miss_run` (4 bits). `expected = Generator(prev)`, combinational.
- **IDLE:** `s_ready=0`. On `start`: clear `match_cnt`, `err_cnt` and `miss_run`.
  - `use_seed=1`: `prev<=seed`, go to CHECK.
  - `use_seed=0`: go to SYNC.
- **SYNC:** an accepted beat does `prev<=s_data` and goes to CHECK. No pulse is produced and no counter changes.
- **CHECK, accepted beat with `s_data==expected`:** `prev<=s_data`, `miss_run<=0`, `match_pulse` next cycle, `match_cnt+1`.
- **CHECK, accepted beat with a mismatch:**
  - `prev<=expected`, so one corrupted word costs exactly one error.
  - `err_pulse` next cycle, `err_cnt+1`, `miss_run+1`.
  - If `miss_run+1 == RESYNC_MISSES`: go to SYNC and clear `miss_run`.
- **start priority:** `start` in SYNC or CHECK behaves as in IDLE; no beat is accepted in that cycle.
- **abort:** go to IDLE. Counters hold their values.
  - `abort` has priority over `start`.
- **Counter saturation:** both counters stop at `2^CNT_W-1`. Comparison and pulses continue.

## Timing
- **Reset values:** with `rst_n=0` at an edge: state IDLE, `prev=0`, `miss_run=0`, and `s_ready`, `locked`, `match_pulse`, `err_pulse`, `match_cnt`, `err_cnt` all 0.
  - Reset mid-stream discards any in-flight result; no pulse follows the reset edge.
- **Latency:** accept at edge N; pulse and counter update are visible after edge N+1. Pulses last exactly one cycle.
- **Throughput:** one beat per cycle, back-to-back.
- **Stall:** `s_valid=0` holds all state. No timeout.
- **locked:** rises the cycle after entering CHECK and falls the cycle after leaving it.
  - The losing mismatch asserts `err_pulse` and deasserts `locked` in the same cycle.
- **Combinational path:** `Generator` plus a 32-bit compare lies between `prev` and the state and `prev` registers. There is no additional pipeline stage.

## Structure
- **Shared package (`prng_pkg`):** `WORD_W=32`, the state enum (`ST_IDLE`, `ST_SYNC`, `ST_CHECK`) and `DEFAULT_SEED=32'd20240301`.
- **Sub-module:** exactly one existing `Generator` instance (32-bit in, 32-bit out, combinational) computes `expected`. No new sub-module.

## Test plan
In the scenarios below, G denotes `Generator`.
1. **Seeded match run.** `start`, `use_seed=1`, `seed=20240301`, then feed G(seed), G²(seed) … for 10 beats → `locked=1`, ten `match_pulse`, `match_cnt=10`, `err_cnt=0`.
2. **Auto-sync.** `start`, `use_seed=0`, feed X=32'h0000_0001 then G(X), G²(X) → no pulse for the first beat, `match_cnt=2`, `locked` high from the cycle after X is accepted.
3. **Single corruption.** Locked stream; replace one word with its value XOR 32'h1, then continue the true sequence → exactly one `err_pulse`, `err_cnt=1`, `locked` stays 1, later beats match.
4. **Lock loss.** Locked, then 4 consecutive bad words (`RESYNC_MISSES=4`) → `err_cnt=4`, `locked=0`. The next word re-seeds, and its successor matches.
5. **Handshake and priority.**
   - Random `s_valid` gaps → counts equal the accepted beats.
   - `start` together with `s_valid` → `s_ready=0` and the beat is not counted.
   - `abort` together with `start` → IDLE.
6. **Reset and saturation.**
   - `rst_n=0` mid-stream → all outputs 0 at the next edge.
   - With `CNT_W=4`, 20 matching beats → `match_cnt=15`.
